// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults for the register file and its scoreboard
// Holds the default DATA_WIDTH / REG_NUM / REG_NUM_BIT values and the
// address of the hardwired zero register.
package regfile_pkg;
   localparam int DATA_WIDTH_DEF  = 32;
   localparam int REG_NUM_DEF     = 32;
   localparam int REG_NUM_BIT_DEF = 5;
   localparam int ZERO_REG        = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits gating instruction issue
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   iss_valid, iss_rs1/rs2/rd        issue request and its operands/destination
//   wen0/1, waddr0/1                 write-back ports (clear busy)
//   iss_ready                        no RAW/WAW hazard this cycle (combinational)
//   busy_cnt                         number of busy registers (registered)
// Macro RF_BYPASS_EN: a register written back this cycle no longer blocks issue.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int REG_NUM     = REG_NUM_DEF,
   parameter int REG_NUM_BIT = REG_NUM_BIT_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   iss_valid,
   input  logic [REG_NUM_BIT-1:0] iss_rs1,
   input  logic [REG_NUM_BIT-1:0] iss_rs2,
   input  logic [REG_NUM_BIT-1:0] iss_rd,
   input  logic                   wen0,
   input  logic [REG_NUM_BIT-1:0] waddr0,
   input  logic                   wen1,
   input  logic [REG_NUM_BIT-1:0] waddr1,
   output logic                   iss_ready,
   output logic [REG_NUM_BIT:0]   busy_cnt
);
   localparam logic [REG_NUM_BIT-1:0] ZERO_ADDR = REG_NUM_BIT'(ZERO_REG);
   logic [REG_NUM-1:0] busy, busy_nxt, busy_eff, clr, set;
   logic [REG_NUM_BIT:0] cnt_nxt;
   // set is applied after clr so an issue wins over a same-cycle write-back
   always_comb begin
      clr = '0;
      set = '0;
      if (wen0 && waddr0 != ZERO_ADDR) clr[waddr0] = 1'b1;
      if (wen1 && waddr1 != ZERO_ADDR) clr[waddr1] = 1'b1;
`ifdef RF_BYPASS_EN
      busy_eff = busy & ~clr;
`else
      busy_eff = busy;
`endif
      iss_ready = !busy_eff[iss_rs1] && !busy_eff[iss_rs2] && !busy_eff[iss_rd];
      if (iss_valid && iss_ready && iss_rd != ZERO_ADDR) set[iss_rd] = 1'b1;
      busy_nxt = (busy & ~clr) | set;
      cnt_nxt = '0;
      for (int i = 0; i < REG_NUM; i++) cnt_nxt = cnt_nxt + (REG_NUM_BIT+1)'(busy_nxt[i]);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-read / two-write register file with issue scoreboard
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   raddr_a/b -> rdata_a/b           combinational reads, x0 reads 0
//   wen0/1, waddr0/1, wdata0/1       write-back ports, port 1 wins on collision
//   iss_valid, iss_rs1/rs2/rd        issue request
//   iss_ready, busy_cnt              scoreboard status (see rf_scoreboard)
// Macro RF_BYPASS_EN: reads forward same-cycle write data (port 1 first).
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int REG_NUM     = REG_NUM_DEF,
   parameter int REG_NUM_BIT = REG_NUM_BIT_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [REG_NUM_BIT-1:0] raddr_a,
   input  logic [REG_NUM_BIT-1:0] raddr_b,
   output logic [DATA_WIDTH-1:0]  rdata_a,
   output logic [DATA_WIDTH-1:0]  rdata_b,
   input  logic                   wen0,
   input  logic                   wen1,
   input  logic [REG_NUM_BIT-1:0] waddr0,
   input  logic [REG_NUM_BIT-1:0] waddr1,
   input  logic [DATA_WIDTH-1:0]  wdata0,
   input  logic [DATA_WIDTH-1:0]  wdata1,
   input  logic                   iss_valid,
   input  logic [REG_NUM_BIT-1:0] iss_rs1,
   input  logic [REG_NUM_BIT-1:0] iss_rs2,
   input  logic [REG_NUM_BIT-1:0] iss_rd,
   output logic                   iss_ready,
   output logic [REG_NUM_BIT:0]   busy_cnt
);
   localparam logic [REG_NUM_BIT-1:0] ZERO_ADDR = REG_NUM_BIT'(ZERO_REG);
   logic [DATA_WIDTH-1:0] rf [REG_NUM];
   // port 1 is written last so it overrides port 0 on the same address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++) rf[i] <= '0;
      end else begin
         if (wen0 && waddr0 != ZERO_ADDR) rf[waddr0] <= wdata0;
         if (wen1 && waddr1 != ZERO_ADDR) rf[waddr1] <= wdata1;
      end
   end
   function automatic logic [DATA_WIDTH-1:0] rd_port(input logic [REG_NUM_BIT-1:0] a);
`ifdef RF_BYPASS_EN
      if (a != ZERO_ADDR && wen1 && waddr1 == a) return wdata1;
      if (a != ZERO_ADDR && wen0 && waddr0 == a) return wdata0;
`endif
      return a == ZERO_ADDR ? '0 : rf[a];
   endfunction
   always_comb rdata_a = rd_port(raddr_a);
   always_comb rdata_b = rd_port(raddr_b);
   rf_scoreboard #(.REG_NUM(REG_NUM), .REG_NUM_BIT(REG_NUM_BIT)) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (iss_valid),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_rd    (iss_rd),
      .wen0      (wen0),
      .waddr0    (waddr0),
      .wen1      (wen1),
      .waddr1    (waddr1),
      .iss_ready (iss_ready),
      .busy_cnt  (busy_cnt)
   );
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter REG_NUM, default 32, number of architectural registers.
REQ-003 SHALL have parameter REG_NUM_BIT, default 5, register address width (log2 REG_NUM).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 raddr_a / raddr_b  input  REG_NUM_BIT  read addresses (rs1, rs2).
REQ-007 rdata_a / rdata_b  output  DATA_WIDTH  read data, combinational.
REQ-008 wen0 / wen1  input  1  write-back enables, ports 0 and 1.
REQ-009 waddr0 / waddr1  input  REG_NUM_BIT  write-back addresses.
REQ-010 wdata0 / wdata1  input  DATA_WIDTH  write-back data.
REQ-011 iss_valid  input  1  issue request for an instruction.
REQ-012 iss_rs1 / iss_rs2 / iss_rd  input  REG_NUM_BIT  issuing instruction's operands and destination.
REQ-013 iss_ready  output  1  issue allowed this cycle (no RAW/WAW hazard), combinational.
REQ-014 busy_cnt  output  REG_NUM_BIT+1  number of registers currently marked busy, registered.

Function
REQ-015 Register 0 SHALL read as 0 on both ports; writes, issues and busy marking targeting address 0 SHALL be ignored.
REQ-016 A write with wenN=1 SHALL update rf[waddrN] at the next posedge; one-cycle write latency.
REQ-017 If wen0 and wen1 target the same nonzero address in the same cycle, port 1 data SHALL be stored (port 0 dropped).
REQ-018 Scoreboard: one busy bit per register; issue handshake = iss_valid && iss_ready.
REQ-019 iss_ready SHALL be 1 iff none of iss_rs1, iss_rs2, iss_rd is busy (address 0 never busy), independent of iss_valid.
REQ-020 Accepted issue with iss_rd!=0 SHALL set busy[iss_rd] at the next posedge.
REQ-021 Any write (either port) to a nonzero address SHALL clear busy[waddr] at the next posedge.
REQ-022 Same-cycle accepted issue and write-back to the same register: busy SHALL remain/become 1 (issue wins, new producer).
REQ-023 busy_cnt SHALL equal the population count of busy bits after each posedge; never exceeds REG_NUM-1.
REQ-024 Write-back to a register not busy SHALL still update data and leave busy 0; no error.

Reset
REQ-025 rst_n=0 SHALL immediately clear all registers to 0, all busy bits to 0, busy_cnt to 0; iss_ready reads 1 during and after reset.
REQ-026 Reset asserted mid-operation SHALL discard all pending writes and issues of that cycle; first update after deassertion occurs on the first posedge with rst_n=1.

Configuration
REQ-027 Macro RF_BYPASS_EN defined: a read address matching an enabled same-cycle write returns that write data (port 1 priority), and a register being written back this cycle SHALL be treated as not busy for iss_ready.
REQ-028 RF_BYPASS_EN undefined: reads return stored value only; busy register being written back this cycle still blocks iss_ready until the following cycle.

Structure
REQ-029 Package regfile_pkg SHALL hold default DATA_WIDTH/REG_NUM/REG_NUM_BIT constants and the zero-register address constant.
REQ-030 Scoreboard SHALL be a separate sub-module rf_scoreboard (busy bits, busy_cnt, iss_ready); data array and bypass muxes stay in regfile_sb.

Verification
REQ-031 Reset, then read all addresses -> every rdata = 0, iss_ready=1, busy_cnt=0.
REQ-032 wen0=1 waddr0=5 wdata0=0xDEADBEEF; next cycle raddr_a=5 -> rdata_a=0xDEADBEEF; write to x0 with 0x1234 -> x0 reads 0.
REQ-033 Issue rd=3 accepted; next cycle issue rs1=3 -> iss_ready=0, busy_cnt=1; write-back waddr1=3 -> with RF_BYPASS_EN iss_ready=1 same cycle, without it 1 cycle later.
REQ-034 Same cycle wen0/wen1 to address 7 with 0x11/0x22 -> rf[7]=0x22; same-cycle issue rd=7 and write-back 7 -> busy[7]=1.
REQ-035 Issue rd=1,2,4 over three cycles then assert rst_n=0 mid-sequence -> all busy cleared, busy_cnt=0, registers 0.
REQ-036 Random issue/write-back stream 10k cycles vs. reference model -> rdata, iss_ready, busy_cnt match every cycle, both macro settings.
